// File: rtl/axis_dwidth_pkg.sv
// rtl/axis_dwidth_pkg.sv - shared helpers for the AXI-Stream width up/down converters
package axis_dwidth_pkg;

    localparam int MIN_NUM_REG = 2;
    localparam int MAX_LANES   = 64;

    typedef logic [MAX_LANES-1:0] lane_mask_t;

    function automatic int lane_idx_w(input int num_reg);
        int w;
        w = $clog2(num_reg);
        return (w < 1) ? 1 : w;
    endfunction

    // Lanes 0..idx set; callers slice the low NUM_REG bits.
    function automatic lane_mask_t keep_upto(input int unsigned idx);
        lane_mask_t m;
        m = '0;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            m[k] = (k <= idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_dwidth_upsizer.sv
// rtl/axis_dwidth_upsizer.sv - packs NUM_REG narrow stream beats into one wide word
module axis_dwidth_upsizer
    import axis_dwidth_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REG = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [WIDTH-1:0]           s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [WIDTH*NUM_REG-1:0]   m_axis_tdata,
    output logic [NUM_REG-1:0]         m_axis_tkeep,
    output logic                       m_axis_tlast
);

    localparam int            IW       = lane_idx_w(NUM_REG);
    localparam int            DW       = WIDTH * NUM_REG;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REG - 1);

    generate
        if (NUM_REG < MIN_NUM_REG || NUM_REG > MAX_LANES) begin : g_bad_num_reg
            $error("axis_dwidth_upsizer: NUM_REG out of range");
        end
    endgenerate

    logic [IW-1:0]      idx;
    logic [DW-1:0]      acc;
    logic [NUM_REG-1:0] kacc;
    logic [DW-1:0]      acc_merged;
    logic [NUM_REG-1:0] keep_merged;
    lane_mask_t         keep_wide;
    logic               unused_keep_wide;
    logic               accept;
    logic               complete;

    // Ready depends only on registers and downstream ready, never on tdata/tlast.
    assign s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && ((idx == LAST_IDX) || s_axis_tlast);

    assign keep_wide        = keep_upto(32'(idx));
    assign unused_keep_wide = ^{1'b0, keep_wide};

    always_comb begin
        acc_merged                          = acc;
        acc_merged[int'(idx)*WIDTH +: WIDTH] = s_axis_tdata;
        keep_merged                         = kacc | keep_wide[NUM_REG-1:0];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            idx           <= '0;
            acc           <= '0;
            kacc          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    idx  <= '0;
                    acc  <= '0;
                    kacc <= '0;
                end else begin
                    idx  <= idx + 1'b1;
                    acc  <= acc_merged;
                    kacc <= keep_merged;
                end
            end
            // A completion can only occur when the output slot is free or draining,
            // so reloading here never overwrites an unconsumed word.
            if (complete) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= acc_merged;
                m_axis_tkeep  <= keep_merged;
                m_axis_tlast  <= s_axis_tlast;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_dwidth_upsizer.sv
// tb/tb_axis_dwidth_upsizer.sv - scoreboard bench for the stream width upsizer
module tb_axis_dwidth_upsizer;

    logic         aclk;
    logic         aresetn;

    logic         a_s_tvalid, a_s_tready, a_s_tlast;
    logic [31:0]  a_s_tdata;
    logic         a_m_tvalid, a_m_tready, a_m_tlast;
    logic [63:0]  a_m_tdata;
    logic [1:0]   a_m_tkeep;

    logic         b_s_tvalid, b_s_tready, b_s_tlast;
    logic [31:0]  b_s_tdata;
    logic         b_m_tvalid, b_m_tready, b_m_tlast;
    logic [127:0] b_m_tdata;
    logic [3:0]   b_m_tkeep;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int a_words = 0;

    logic [63:0] exp_d[$];
    logic [1:0]  exp_k[$];
    logic        exp_l[$];
    logic [63:0] ed;
    logic [1:0]  ek;
    logic        el;

    logic [63:0] mdl_acc;
    logic [1:0]  mdl_keep;
    int          mdl_idx;

    axis_dwidth_upsizer #(.WIDTH(32), .NUM_REG(2)) dut_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .s_axis_tdata(a_s_tdata), .s_axis_tlast(a_s_tlast),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tlast(a_m_tlast)
    );

    axis_dwidth_upsizer #(.WIDTH(32), .NUM_REG(4)) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Output word handshakes at the coming posedge are visible at this negedge.
    always @(negedge aclk) begin
        if (aresetn && a_m_tvalid && a_m_tready) begin
            a_words++;
            tests++;
            if (exp_d.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h/%b/%b, required no word", a_m_tdata, a_m_tkeep, a_m_tlast);
            end else begin
                ed = exp_d.pop_front();
                ek = exp_k.pop_front();
                el = exp_l.pop_front();
                if (a_m_tdata !== ed || a_m_tkeep !== ek || a_m_tlast !== el) begin
                    fails++;
                    $display("FAIL sb_word: got %h/%b/%b, required %h/%b/%b",
                             a_m_tdata, a_m_tkeep, a_m_tlast, ed, ek, el);
                end
            end
        end
    end

    task automatic model_clear();
        mdl_acc  = '0;
        mdl_keep = '0;
        mdl_idx  = 0;
    endtask

    task automatic model_beat_a(input logic [31:0] d, input logic l);
        mdl_acc[mdl_idx*32 +: 32] = d;
        mdl_keep[mdl_idx]         = 1'b1;
        if (mdl_idx == 1 || l) begin
            exp_d.push_back(mdl_acc);
            exp_k.push_back(mdl_keep);
            exp_l.push_back(l);
            model_clear();
        end else begin
            mdl_idx++;
        end
    endtask

    task automatic send_beat_a(input logic [31:0] d, input logic l);
        bit ok;
        ok = 0;
        a_s_tvalid = 1'b1;
        a_s_tdata  = d;
        a_s_tlast  = l;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge aclk);
            if (a_s_tready) ok = 1;
            @(posedge aclk);
            #1;
        end
        a_s_tvalid = 1'b0;
        if (ok) model_beat_a(d, l);
        else begin
            tests++;
            fails++;
            $display("FAIL a_send_timeout: got no tready, required accept of %h", d);
        end
    endtask

    task automatic send_beat_b(input logic [31:0] d, input logic l);
        bit ok;
        ok = 0;
        b_s_tvalid = 1'b1;
        b_s_tdata  = d;
        b_s_tlast  = l;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge aclk);
            if (b_s_tready) ok = 1;
            @(posedge aclk);
            #1;
        end
        b_s_tvalid = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b_send_timeout: got no tready, required accept of %h", d);
        end
    endtask

    task automatic test_reset();
        aresetn    = 1'b0;
        a_s_tvalid = 1'b1;
        b_s_tvalid = 1'b1;
        repeat (4) begin
            @(posedge aclk);
            @(negedge aclk);
            tests++;
            if (a_s_tready !== 1'b0 || a_m_tvalid !== 1'b0 || a_m_tdata !== 64'h0 || b_s_tready !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: got tready=%b tvalid=%b tdata=%h btready=%b, required 0/0/0/0",
                         a_s_tready, a_m_tvalid, a_m_tdata, b_s_tready);
            end
        end
        @(posedge aclk);
        #1;
        a_s_tvalid = 1'b0;
        b_s_tvalid = 1'b0;
        aresetn    = 1'b1;
        model_clear();
    endtask

    task automatic test_full_word();
        a_m_tready = 1'b1;
        send_beat_a(32'h1111_1111, 1'b0);
        send_beat_a(32'h2222_2222, 1'b1);
        tests++;
        if (a_m_tvalid !== 1'b1 || a_m_tdata !== 64'h2222_2222_1111_1111 || a_m_tkeep !== 2'b11 || a_m_tlast !== 1'b1) begin
            fails++;
            $display("FAIL full_word: got %b/%h/%b/%b, required 1/2222222211111111/11/1",
                     a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast);
        end
        @(posedge aclk);
        #1;
        tests++;
        if (a_m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL full_word_pulse: got tvalid=%b, required 0", a_m_tvalid);
        end
    endtask

    task automatic test_early_tlast();
        b_m_tready = 1'b1;
        send_beat_b(32'hA, 1'b0);
        send_beat_b(32'hB, 1'b1);
        tests++;
        if (b_m_tvalid !== 1'b1 || b_m_tdata !== {32'h0, 32'h0, 32'hB, 32'hA} || b_m_tkeep !== 4'b0011 || b_m_tlast !== 1'b1) begin
            fails++;
            $display("FAIL early_tlast: got %b/%h/%b/%b, required 1/{0,0,B,A}/0011/1",
                     b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast);
        end
        send_beat_b(32'hC, 1'b0);
        send_beat_b(32'hD, 1'b0);
        send_beat_b(32'hE, 1'b0);
        send_beat_b(32'hF, 1'b1);
        tests++;
        if (b_m_tdata !== {32'hF, 32'hE, 32'hD, 32'hC} || b_m_tkeep !== 4'b1111 || b_m_tlast !== 1'b1) begin
            fails++;
            $display("FAIL lane0_restart: got %h/%b/%b, required {F,E,D,C}/1111/1", b_m_tdata, b_m_tkeep, b_m_tlast);
        end
        send_beat_b(32'h9, 1'b1);
        tests++;
        if (b_m_tdata !== {96'h0, 32'h9} || b_m_tkeep !== 4'b0001 || b_m_tlast !== 1'b1) begin
            fails++;
            $display("FAIL tlast_lane0: got %h/%b/%b, required {0,0,0,9}/0001/1", b_m_tdata, b_m_tkeep, b_m_tlast);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        a_m_tready = 1'b0;
        send_beat_a(32'h31, 1'b0);
        send_beat_a(32'h32, 1'b0);
        a_s_tvalid = 1'b1;
        a_s_tdata  = 32'h33;
        a_s_tlast  = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            tests++;
            if (a_s_tready !== 1'b0 || a_m_tvalid !== 1'b1 || a_m_tdata !== 64'h0000_0032_0000_0031 || a_m_tkeep !== 2'b11) begin
                fails++;
                $display("FAIL backpressure_hold: got tready=%b tvalid=%b tdata=%h tkeep=%b, required 0/1/0000003200000031/11",
                         a_s_tready, a_m_tvalid, a_m_tdata, a_m_tkeep);
            end
        end
        @(posedge aclk);
        #1;
        a_m_tready = 1'b1;
        @(negedge aclk);
        seen = a_s_tready;
        tests++;
        if (seen !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: got tready=%b, required 1", seen);
        end
        @(posedge aclk);
        #1;
        a_s_tvalid = 1'b0;
        if (seen) model_beat_a(32'h33, 1'b0);
        send_beat_a(32'h34, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        tests++;
        if (exp_d.size() != 0) begin
            fails++;
            $display("FAIL backpressure_drain: got %0d words pending, required 0", exp_d.size());
        end
    endtask

    task automatic test_back_to_back();
        int start_cyc, start_words;
        a_m_tready  = 1'b1;
        start_words = a_words;
        start_cyc   = cyc;
        for (int i = 0; i < 64; i++) begin
            send_beat_a($urandom, (i % 2 == 1) && ($urandom_range(0, 3) == 0));
        end
        tests++;
        if (cyc - start_cyc != 64) begin
            fails++;
            $display("FAIL throughput_cycles: got %0d cycles, required 64", cyc - start_cyc);
        end
        repeat (3) @(posedge aclk);
        #1;
        tests++;
        if (a_words - start_words != 32) begin
            fails++;
            $display("FAIL throughput_words: got %0d words, required 32", a_words - start_words);
        end
    endtask

    task automatic test_reset_mid_packet();
        a_m_tready = 1'b1;
        send_beat_a(32'h5, 1'b0);
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_clear();
        tests++;
        if (a_m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_tvalid: got %b, required 0", a_m_tvalid);
        end
        send_beat_a(32'h6, 1'b0);
        send_beat_a(32'h7, 1'b1);
        tests++;
        if (a_m_tdata !== 64'h0000_0007_0000_0006 || a_m_tkeep !== 2'b11) begin
            fails++;
            $display("FAIL reset_mid_packing: got %h/%b, required 0000000700000006/11", a_m_tdata, a_m_tkeep);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_random();
        int  nacc, ncyc;
        bit  acc_ok;
        nacc = 0;
        ncyc = 0;
        a_s_tvalid = 1'b0;
        while (nacc < 200 && ncyc < 5000) begin
            if (!a_s_tvalid && $urandom_range(0, 2) != 0) begin
                a_s_tvalid = 1'b1;
                a_s_tdata  = $urandom;
                a_s_tlast  = ($urandom_range(0, 4) == 0);
            end
            a_m_tready = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            acc_ok = a_s_tvalid && a_s_tready;
            @(posedge aclk);
            #1;
            ncyc++;
            if (acc_ok) begin
                model_beat_a(a_s_tdata, a_s_tlast);
                nacc++;
                a_s_tvalid = 1'b0;
            end
        end
        tests++;
        if (nacc != 200) begin
            fails++;
            $display("FAIL random_accept: got %0d beats, required 200", nacc);
        end
        a_m_tready = 1'b1;
        send_beat_a(32'hFEED_0001, 1'b1);
        for (int c = 0; c < 20 && exp_d.size() != 0; c++) @(posedge aclk);
        #1;
        tests++;
        if (exp_d.size() != 0) begin
            fails++;
            $display("FAIL random_drain: got %0d words pending, required 0", exp_d.size());
        end
    endtask

    initial begin
        aresetn    = 1'b0;
        a_s_tvalid = 1'b0;
        a_s_tdata  = '0;
        a_s_tlast  = 1'b0;
        a_m_tready = 1'b0;
        b_s_tvalid = 1'b0;
        b_s_tdata  = '0;
        b_s_tlast  = 1'b0;
        b_m_tready = 1'b1;
        model_clear();

        test_reset();
        test_full_word();
        test_early_tlast();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
